// File: rtl/dma_copier.sv
// dma_copier: memory-to-memory word copy engine acting as a second bus initiator.
//
// Ports
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   a_i        register word index (responder side)
//   d_i        register write data
//   we_i       register write strobe, one cycle
//   spo_o      register read data, combinational from a_i
//   m_a_o      initiator byte address
//   m_d_o      initiator write data
//   m_we_o     initiator write request
//   m_rd_o     initiator read request
//   m_spo_i    initiator read data
//   m_ready_i  initiator access complete
//   irq_o      level interrupt (done & ie, registered)
//
// Register map: 0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS, 4 REMAIN, 5-7 reserved (read 0).
//
// state | meaning
// IDLE  | no transfer in progress
// RD    | read request held until m_ready_i
// RGAP  | strobes low for one cycle after the read
// WR    | write request held until m_ready_i
// WGAP  | strobes low for one cycle, then next word or finish
module dma_copier #(
  parameter int TIMEOUT = 1024,
  parameter int LEN_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  a_i,
  input  logic [31:0] d_i,
  input  logic        we_i,
  output logic [31:0] spo_o,
  output logic [31:0] m_a_o,
  output logic [31:0] m_d_o,
  output logic        m_we_o,
  output logic        m_rd_o,
  input  logic [31:0] m_spo_i,
  input  logic        m_ready_i,
  output logic        irq_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RGAP = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_WGAP = 3'd4;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [31:0]      cur_src_q, cur_src_d;
  logic [31:0]      cur_dst_q, cur_dst_d;
  logic [31:0]      buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ie_q, ie_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             irq_q, irq_d;

  logic busy;
  logic ctrl_wr;

  assign busy    = (state_q != S_IDLE);
  assign ctrl_wr = we_i && (a_i == 3'd3);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    remain_d  = remain_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    ie_d      = ie_q;
    done_d    = done_q;
    err_d     = err_q;

    if (we_i && !busy) begin
      case (a_i)
        3'd0:    src_d = {d_i[31:2], 2'b00};
        3'd1:    dst_d = {d_i[31:2], 2'b00};
        3'd2:    len_d = d_i[LEN_W-1:0];
        default: ;
      endcase
    end

    if (ctrl_wr) begin
      ie_d = d_i[3];
      // Clear is applied before the FSM so a completion in the same cycle wins.
      if (d_i[1]) begin
        done_d = 1'b0;
        err_d  = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && d_i[0] && !d_i[2]) begin
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            cur_src_d = src_q;
            cur_dst_d = dst_q;
            remain_d  = len_q;
            cnt_d     = '0;
            state_d   = S_RD;
          end
        end
      end
      S_RD: begin
        if (m_ready_i) begin
          buf_d   = m_spo_i;
          state_d = S_RGAP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RGAP: begin
        cnt_d   = '0;
        state_d = S_WR;
      end
      S_WR: begin
        if (m_ready_i) begin
          cur_src_d = cur_src_q + 32'd4;
          cur_dst_d = cur_dst_q + 32'd4;
          remain_d  = remain_q - LEN_W'(1);
          state_d   = S_WGAP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WGAP: begin
        cnt_d = '0;
        if (remain_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything else, including a same-cycle completion.
    if (ctrl_wr && d_i[2] && busy) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    irq_d = done_d & ie_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      remain_q  <= '0;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      remain_q  <= remain_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      ie_q      <= ie_d;
      done_q    <= done_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
    end
  end

  // Bus outputs decode straight from state so a reset drops the strobes at once.
  assign m_rd_o = (state_q == S_RD);
  assign m_we_o = (state_q == S_WR);
  assign m_a_o  = (state_q == S_RD) ? cur_src_q :
                  (state_q == S_WR) ? cur_dst_q : 32'd0;
  assign m_d_o  = (state_q == S_WR) ? buf_q : 32'd0;
  assign irq_o  = irq_q;

  always_comb begin
    spo_o = 32'd0;
    case (a_i)
      3'd0:    spo_o = src_q;
      3'd1:    spo_o = dst_q;
      3'd2:    spo_o = 32'(len_q);
      3'd3:    spo_o = {28'd0, ie_q, err_q, done_q, busy};
      3'd4:    spo_o = 32'(remain_q);
      default: spo_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dma_copier.sv
module tb_dma_copier;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [2:0]  a_i = '0;
  logic [31:0] d_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] spo_o;
  logic [31:0] m_a_o;
  logic [31:0] m_d_o;
  logic        m_we_o;
  logic        m_rd_o;
  logic [31:0] m_spo_i = 32'hDEADBEEF;
  logic        m_ready_i = 1'b0;
  logic        irq_o;

  dma_copier #(.TIMEOUT(16), .LEN_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .a_i(a_i), .d_i(d_i), .we_i(we_i),
    .spo_o(spo_o), .m_a_o(m_a_o), .m_d_o(m_d_o), .m_we_o(m_we_o),
    .m_rd_o(m_rd_o), .m_spo_i(m_spo_i), .m_ready_i(m_ready_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata(input logic [31:0] addr);
    case (addr)
      32'h2000: rdata = 32'h0000_00A1;
      32'h2004: rdata = 32'h0000_00B2;
      32'h2008: rdata = 32'h0000_00C3;
      default:  rdata = ~addr;
    endcase
  endfunction

  // ---------------- memory responder ----------------
  typedef struct {logic we; logic [31:0] a; logic [31:0] d;} acc_t;
  acc_t log_q[$];
  acc_t exp_q[$];

  int          rd_lat = 0;
  int          wr_lat = 0;
  int          hold = 0;
  int          strobe_cyc = 0;
  logic        acc_active = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] hold_a, hold_d;
  logic        hold_we;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      acc_active = 1'b0;
      prev_ready = 1'b0;
      m_ready_i  = 1'b0;
      m_spo_i    = 32'hDEADBEEF;
    end else begin
      if (prev_ready) chk("gap_after_ready", {30'd0, m_rd_o, m_we_o}, 32'd0);
      if (m_rd_o || m_we_o) begin
        strobe_cyc++;
        if (m_rd_o && m_we_o) chk("rd_we_both", 32'd1, 32'd0);
        if (!acc_active) begin
          acc_active = 1'b1;
          hold    = 0;
          hold_a  = m_a_o;
          hold_d  = m_d_o;
          hold_we = m_we_o;
        end else begin
          chk("hold_addr", m_a_o, hold_a);
          chk("hold_we", {31'd0, m_we_o}, {31'd0, hold_we});
          if (m_we_o) chk("hold_data", m_d_o, hold_d);
        end
        if (hold == (m_we_o ? wr_lat : rd_lat)) begin
          m_ready_i = 1'b1;
          if (m_we_o) begin
            m_spo_i = 32'hDEADBEEF;
            log_q.push_back('{1'b1, m_a_o, m_d_o});
          end else begin
            m_spo_i = rdata(m_a_o);
            log_q.push_back('{1'b0, m_a_o, m_spo_i});
          end
        end else begin
          m_ready_i = 1'b0;
          m_spo_i   = 32'hDEADBEEF;
        end
        hold++;
      end else begin
        acc_active = 1'b0;
        m_ready_i  = 1'b0;
        m_spo_i    = 32'hDEADBEEF;
      end
      prev_ready = m_ready_i;
    end
  end

  // ---------------- helpers ----------------
  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    a_i = a; d_i = d; we_i = 1'b1;
    @(posedge clk_i); #1;
    we_i = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] v);
    a_i = a;
    #1;
    v = spo_o;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_i); #1;
      cyc++;
      a_i = 3'd3;
      #1;
      if (spo_o[1]) break;
    end
  endtask

  task automatic build_exp(input logic [31:0] src, input logic [31:0] dst, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, src + 32'(4 * i), rdata(src + 32'(4 * i))});
      exp_q.push_back('{1'b1, dst + 32'(4 * i), rdata(src + 32'(4 * i))});
    end
  endtask

  task automatic check_log(input string tag);
    chk($sformatf("%s_count", tag), 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s_%0d_we", tag, i), {31'd0, log_q[i].we}, {31'd0, exp_q[i].we});
      chk($sformatf("%s_%0d_addr", tag, i), log_q[i].a, exp_q[i].a);
      chk($sformatf("%s_%0d_data", tag, i), log_q[i].d, exp_q[i].d);
    end
  endtask

  typedef struct {logic we; logic [2:0] a; logic [31:0] d; logic [31:0] exp;} vec_t;
  vec_t tbl[19];

  initial begin
    logic [31:0] v;
    int          cyc;
    int          cnt;
    int          snap;

    tbl = '{
      '{1'b0, 3'd0, 32'h0,          32'h0},
      '{1'b0, 3'd1, 32'h0,          32'h0},
      '{1'b0, 3'd2, 32'h0,          32'h0},
      '{1'b0, 3'd3, 32'h0,          32'h0},
      '{1'b0, 3'd4, 32'h0,          32'h0},
      '{1'b1, 3'd0, 32'h1234_5677,  32'h0},
      '{1'b0, 3'd0, 32'h0,          32'h1234_5674},
      '{1'b1, 3'd1, 32'hFFFF_FFFF,  32'h0},
      '{1'b0, 3'd1, 32'h0,          32'hFFFF_FFFC},
      '{1'b1, 3'd2, 32'h0003_ABCD,  32'h0},
      '{1'b0, 3'd2, 32'h0,          32'h0000_ABCD},
      '{1'b1, 3'd3, 32'h0000_0008,  32'h0},
      '{1'b0, 3'd3, 32'h0,          32'h0000_0008},
      '{1'b1, 3'd5, 32'hFFFF_FFFF,  32'h0},
      '{1'b0, 3'd5, 32'h0,          32'h0},
      '{1'b0, 3'd6, 32'h0,          32'h0},
      '{1'b0, 3'd7, 32'h0,          32'h0},
      '{1'b1, 3'd3, 32'h0000_0000,  32'h0},
      '{1'b0, 3'd3, 32'h0,          32'h0}
    };

    #12 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_m_rd", {31'd0, m_rd_o}, 32'd0);
    chk("rst_m_we", {31'd0, m_we_o}, 32'd0);
    chk("rst_m_a", m_a_o, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);

    // register table
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].we) begin
        reg_write(tbl[i].a, tbl[i].d);
      end else begin
        reg_read(tbl[i].a, v);
        chk($sformatf("tbl%0d_a%0d", i, tbl[i].a), v, tbl[i].exp);
      end
    end

    // basic copy, zero wait
    rd_lat = 0; wr_lat = 0; log_q.delete();
    reg_write(3'd0, 32'h2000);
    reg_write(3'd1, 32'h2100);
    reg_write(3'd2, 32'd3);
    reg_write(3'd3, 32'h9);
    wait_done(cyc);
    chk("basic_cycles", 32'(cyc), 32'd12);
    chk("basic_irq", {31'd0, irq_o}, 32'd1);
    reg_read(3'd3, v);
    chk("basic_status", v, 32'hA);
    exp_q.delete();
    exp_q.push_back('{1'b0, 32'h2000, 32'hA1});
    exp_q.push_back('{1'b1, 32'h2100, 32'hA1});
    exp_q.push_back('{1'b0, 32'h2004, 32'hB2});
    exp_q.push_back('{1'b1, 32'h2104, 32'hB2});
    exp_q.push_back('{1'b0, 32'h2008, 32'hC3});
    exp_q.push_back('{1'b1, 32'h2108, 32'hC3});
    check_log("basic");
    @(posedge clk_i); #1;
    chk("irq_holds", {31'd0, irq_o}, 32'd1);
    reg_write(3'd3, 32'hA);
    chk("irq_cleared", {31'd0, irq_o}, 32'd0);
    reg_read(3'd3, v);
    chk("clear_status", v, 32'h8);

    // wait states
    rd_lat = 5; wr_lat = 5; log_q.delete();
    reg_write(3'd0, 32'h3000);
    reg_write(3'd1, 32'h3100);
    reg_write(3'd2, 32'd2);
    reg_write(3'd3, 32'h9);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_i); #1;
      if (log_q.size() >= 2) break;
    end
    reg_read(3'd4, v);
    chk("wait_remain_after_w1", v, 32'd1);
    wait_done(cyc);
    build_exp(32'h3000, 32'h3100, 2);
    check_log("wait");
    reg_write(3'd3, 32'h2);

    // timeout: no ready at all
    rd_lat = 1000; wr_lat = 1000; log_q.delete();
    reg_write(3'd0, 32'h3800);
    reg_write(3'd2, 32'd4);
    reg_write(3'd3, 32'h1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (m_rd_o) cnt++;
    end
    chk("timeout_rd_cycles", 32'(cnt), 32'd16);
    chk("timeout_rd_low", {31'd0, m_rd_o}, 32'd0);
    reg_read(3'd3, v);
    chk("timeout_status", v, 32'h6);
    reg_read(3'd4, v);
    chk("timeout_remain", v, 32'd4);
    chk("timeout_irq", {31'd0, irq_o}, 32'd0);
    @(posedge clk_i); #1;

    // abort mid-WR and busy writes
    reg_write(3'd3, 32'h2);
    rd_lat = 0; wr_lat = 1000; log_q.delete();
    reg_write(3'd0, 32'h4000);
    reg_write(3'd1, 32'h4100);
    reg_write(3'd2, 32'd2);
    reg_write(3'd3, 32'h1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (m_we_o) break;
    end
    chk("abort_in_wr", {31'd0, m_we_o}, 32'd1);
    @(posedge clk_i); #1;
    reg_write(3'd0, 32'hDEAD0000);
    reg_read(3'd0, v);
    chk("busy_src_ignored", v, 32'h4000);
    reg_write(3'd3, 32'h4);
    chk("abort_m_we", {31'd0, m_we_o}, 32'd0);
    reg_read(3'd3, v);
    chk("abort_status", v, 32'h0);
    reg_read(3'd4, v);
    chk("abort_remain", v, 32'd2);

    // LEN=0 start
    reg_write(3'd2, 32'd0);
    snap = strobe_cyc;
    reg_write(3'd3, 32'h1);
    reg_read(3'd3, v);
    chk("len0_status", v, 32'h2);
    repeat (3) @(posedge clk_i);
    #1;
    chk("len0_no_strobes", 32'(strobe_cyc), 32'(snap));

    // clear + start while done=1
    rd_lat = 0; wr_lat = 0; log_q.delete();
    reg_write(3'd0, 32'h5000);
    reg_write(3'd1, 32'h5100);
    reg_write(3'd2, 32'd1);
    reg_write(3'd3, 32'h3);
    reg_read(3'd3, v);
    chk("clrstart_status", v, 32'h1);
    wait_done(cyc);
    chk("clrstart_cycles", 32'(cyc), 32'd4);
    build_exp(32'h5000, 32'h5100, 1);
    check_log("clrstart");

    // reset mid-RD
    rd_lat = 1000; wr_lat = 1000;
    reg_write(3'd0, 32'h7000);
    reg_write(3'd1, 32'h7100);
    reg_write(3'd2, 32'd3);
    reg_write(3'd3, 32'h9);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_m_rd", {31'd0, m_rd_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_m_rd", {31'd0, m_rd_o}, 32'd0);
    chk("async_rst_m_a", m_a_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    for (int r = 0; r < 8; r++) begin
      reg_read(3'(r), v);
      chk($sformatf("post_rst_reg%0d", r), v, 32'd0);
    end
    chk("post_rst_irq", {31'd0, irq_o}, 32'd0);

    // destination wrap
    rd_lat = 0; wr_lat = 0; log_q.delete();
    reg_write(3'd0, 32'h6000);
    reg_write(3'd1, 32'hFFFF_FFFC);
    reg_write(3'd2, 32'd2);
    reg_write(3'd3, 32'h1);
    wait_done(cyc);
    chk("wrap_cycles", 32'(cyc), 32'd8);
    reg_read(3'd3, v);
    chk("wrap_status", v, 32'h2);
    build_exp(32'h6000, 32'hFFFF_FFFC, 2);
    check_log("wrap");
    chk("wrap_second_addr", exp_q[3].a, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_copier.md
Name: dma_copier

Overview:
- Memory-to-memory word copy engine; a second bus initiator beside riscv_multicyc.
- Programmed by the CPU through a small register responder port, decoded by mmapper like the uart/gpio slots.
- Drives its own a/d/we/rd/spo/ready initiator port into the memory side (bootrom/distram/mainm), arbitrated upstream.
- Raises a level irq toward interrupt_unit on completion or error.

Parameters:
- TIMEOUT, 1024: maximum cycles waiting for m_ready in one access before the transfer aborts with error.
- LEN_W, 16: width of the word-count register.

Ports:
- clk  in  1  system clock (clk_main)
- rst  in  1  asynchronous, active-low reset
- a  in  3  register word index
- d  in  32  register write data
- we  in  1  register write strobe, one cycle
- spo  out  32  register read data, combinational from a
- m_a  out  32  initiator byte address
- m_d  out  32  initiator write data
- m_we  out  1  initiator write request
- m_rd  out  1  initiator read request
- m_spo  in  32  initiator read data
- m_ready  in  1  initiator access complete
- irq  out  1  level interrupt

Behaviour:
- Registers (a):
  - 0 SRC: RW; bits[1:0] forced 0.
  - 1 DST: RW; bits[1:0] forced 0.
  - 2 LEN: RW, LEN_W bits, zero-extended on read.
  - 3 CTRL/STATUS:
    - Write bits: [0] start, [1] clear done/err, [2] abort, [3] ie (stored).
    - Read bits: [0] busy, [1] done, [2] err, [3] ie.
  - 4 REMAIN: RO, words left.
  - 5-7: read 0, writes ignored.
- Reset (rst=0):
  - State IDLE.
  - SRC, DST, LEN, REMAIN, ie, done, err, data buffer all 0.
  - m_a=0, m_d=0, m_we=0, m_rd=0, irq=0.
  - A reset mid-transfer drops m_rd/m_we immediately (asynchronously).
- Writes to SRC/DST/LEN while busy are ignored; ie is writable at any time.
- FSM states: IDLE, RD, RGAP, WR, WGAP.
  - IDLE:
    - CTRL write with start=1 and LEN!=0: latch cur_src=SRC, cur_dst=DST, REMAIN=LEN; next state RD.
    - start with LEN==0: done=1 next cycle; no bus access.
    - If start and clear are in the same write, clear applies first, then start.
  - RD:
    - m_a=cur_src, m_rd=1, m_we=0; held until m_ready is sampled 1.
    - On that edge: buffer<=m_spo; next state RGAP.
  - RGAP: one cycle, m_rd=m_we=0, so a stale ready is never reused; next state WR.
  - WR:
    - m_a=cur_dst, m_d=buffer, m_we=1, held until m_ready is sampled 1.
    - On that edge: cur_src+=4, cur_dst+=4, REMAIN-=1; next state WGAP.
  - WGAP:
    - Strobes low for one cycle.
    - REMAIN==0: IDLE, done=1.
    - Otherwise: RD.
- Per-word cost: 2 + read latency + write latency cycles.
  - Minimum 4 cycles per word when ready comes back in the first cycle of each access.
- Addresses wrap modulo 2^32 with no error.
- Timeout:
  - Counter clears on entry to RD/WR and increments each cycle there without m_ready.
  - On reaching TIMEOUT: strobes drop the next cycle, state IDLE, err=1, done=1.
  - REMAIN holds the failed word count.
- Abort:
  - CTRL write with abort=1 while busy: IDLE next cycle, strobes low, done=0, err=0; REMAIN keeps its value.
  - An in-flight access is abandoned.
  - Abort in IDLE has no effect.
  - abort and start in the same write: abort wins and start is ignored.
- Start while busy is ignored.
- busy = (state != IDLE).
- irq = done & ie, registered; it stays high until a clear write or ie=0.
- Completion and a clear write in the same cycle: completion wins, so done stays 1.

Test Plan:
- Basic copy: SRC=0x2000, DST=0x2100, LEN=3, ie=1, start; responder returns 0xA1,0xB2,0xC3 with 0-wait ready. Required:
  - three RD/WR pairs at 0x2000/0x2100, 0x2004/0x2104, 0x2008/0x2108;
  - m_d matches each read word;
  - strobes low between every access;
  - done=1 and irq=1 exactly 12 cycles after the start write.
- Wait states: ready delayed 5 cycles on each access, LEN=2. Required:
  - strobes and address held stable through every wait;
  - buffer captured only on the ready edge;
  - REMAIN reads 1 after the first write completes.
- Timeout: TIMEOUT=16, ready never asserted, LEN=4. Required: m_rd high exactly 16 cycles, then low; status=0b0110 with ie=0; REMAIN=4.
- Abort and busy writes:
  - abort mid-WR: m_we low the next cycle, busy=0, done=0.
  - SRC write while busy: ignored, reads back the old value.
  - clear together with start while done=1: done clears and the new transfer begins.
- Reset edge cases:
  - LEN=0 start: done=1 the next cycle, no m_rd/m_we pulses.
  - rst low mid-RD: m_rd=0 immediately; all registers and spo reads 0 after release.
  - DST=0xFFFFFFFC, LEN=2: second write at 0x00000000.
